// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and op-class helpers for the multiply/divide accelerator.
package muldiv_pkg;
  typedef enum logic [1:0] {DIVU = 2'b00, DIVS = 2'b01, MULU = 2'b10, MULS = 2'b11} t_md_op;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} t_md_state;

  function automatic logic is_signed(t_md_op op);
    return (op == DIVS) || (op == MULS);
  endfunction

  function automatic logic isMul(t_md_op op);
    return (op == MULU) || (op == MULS);
  endfunction
endpackage

// File: rtl/muldiv_acc_if.sv
// Request/result handshake bundle between decode and the multiply/divide unit.
interface muldiv_acc_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out_r;
  logic             out_dz;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_q, out_r, out_dz, out_tag
  );
  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_q, out_r, out_dz, out_tag
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: restoring-divide step or LSB-first shift-add multiply step.
module muldiv_step #(
  parameter int WIDTH = 16
) (
  input  logic             isMulOp,
  input  logic [WIDTH:0]   hi,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   hiNxt,
  output logic [WIDTH-1:0] loNxt
);
  logic [WIDTH:0] trial;
  logic [WIDTH:0] sum;

  always_comb begin
    trial = {hi[WIDTH-1:0], lo[WIDTH-1]};
    sum   = hi + {1'b0, b};
    hiNxt = trial;
    loNxt = {lo[WIDTH-2:0], 1'b0};
    if (isMulOp) begin
      // product accumulates in hi, multiplier bits retire out of lo
      if (lo[0]) begin
        hiNxt = {1'b0, sum[WIDTH:1]};
        loNxt = {sum[0], lo[WIDTH-1:1]};
      end else begin
        hiNxt = {1'b0, hi[WIDTH:1]};
        loNxt = {hi[0], lo[WIDTH-1:1]};
      end
    end else if (trial >= {1'b0, b}) begin
      hiNxt = trial - {1'b0, b};
      loNxt = {lo[WIDTH-2:0], 1'b1};
    end
  end
endmodule

// File: rtl/muldiv_acc.sv
// Multi-cycle signed/unsigned multiply/divide with valid/ready handshake and abort flush.
module muldiv_acc
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SPC   = 1,
  parameter int TAG_W = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic abort,
  output logic busy,
  muldiv_acc_if.slave bus
);
  localparam int ITER = WIDTH / SPC;
  localparam int CW   = $clog2(ITER + 1);

  t_md_state state, stateNxt;
  t_md_op    op, inOp;
  logic [CW-1:0] cnt;
  logic accept, divZero, mulOp, negQ, negR;
  logic [WIDTH-1:0] aMagIn, bMagIn, bMag, lo, fixQ, fixR;
  logic [WIDTH:0]   hi;
  logic [2*WIDTH-1:0] prodRaw, prod;
  logic [SPC:0][WIDTH:0]   hiChain;
  logic [SPC:0][WIDTH-1:0] loChain;

  assign inOp    = t_md_op'(bus.in_op);
  assign accept  = bus.in_valid && bus.in_ready;
  assign divZero = !isMul(inOp) && (bus.in_b == '0);
  assign mulOp   = isMul(op);
  // |MIN| wraps to 2^(WIDTH-1), which is exactly the unsigned magnitude wanted
  assign aMagIn  = (is_signed(inOp) && bus.in_a[WIDTH-1]) ? -bus.in_a : bus.in_a;
  assign bMagIn  = (is_signed(inOp) && bus.in_b[WIDTH-1]) ? -bus.in_b : bus.in_b;

  assign hiChain[0] = hi;
  assign loChain[0] = lo;
  for (genvar i = 0; i < SPC; i++) begin : g_step
    muldiv_step #(.WIDTH(WIDTH)) uStep (
      .isMulOp(mulOp), .hi(hiChain[i]), .lo(loChain[i]), .b(bMag),
      .hiNxt(hiChain[i+1]), .loNxt(loChain[i+1])
    );
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (accept) stateNxt = divZero ? DONE : CALC;
      CALC:    if (cnt == CW'(1)) stateNxt = FIX;
      FIX:     stateNxt = DONE;
      DONE:    if (bus.out_ready) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    if (abort) stateNxt = IDLE;
  end

  always_comb begin
    bus.in_ready = (state == IDLE) && !abort;
    busy         = (state != IDLE);
  end

  always_comb begin
    prodRaw = {hi[WIDTH-1:0], lo};
    prod    = negQ ? -prodRaw : prodRaw;
    fixQ    = negQ ? -lo : lo;
    fixR    = negR ? -hi[WIDTH-1:0] : hi[WIDTH-1:0];
    if (mulOp) begin
      fixQ = prod[WIDTH-1:0];
      fixR = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op   <= inOp;
      bMag <= bMagIn;
      hi   <= '0;
      lo   <= aMagIn;
      negQ <= is_signed(inOp) && (bus.in_a[WIDTH-1] ^ bus.in_b[WIDTH-1]);
      negR <= is_signed(inOp) && bus.in_a[WIDTH-1];
    end else if (state == CALC) begin
      hi <= hiChain[SPC];
      lo <= loChain[SPC];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_q     <= '0;
      bus.out_r     <= '0;
      bus.out_dz    <= 1'b0;
      bus.out_tag   <= '0;
    end else begin
      bus.out_valid <= (stateNxt == DONE);
      if (accept) cnt <= CW'(ITER);
      else if (state == CALC) cnt <= cnt - CW'(1);
      if (accept) begin
        bus.out_tag <= bus.in_tag;
        bus.out_dz  <= divZero;
        if (divZero) begin
          bus.out_q <= '1;
          bus.out_r <= bus.in_a;
        end
      end else if (state == FIX) begin
        bus.out_q <= fixQ;
        bus.out_r <= fixR;
      end
    end
  end
endmodule
